regfile_wr_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback path and a variable-latency late requester, such as a multi-cycle load unit. It sits between the writeback-data mux and the register file. The block does three things: it arbitrates the write port with a starvation guard, it registers the winning write, and it keeps a pending-destination scoreboard. Decode uses that scoreboard to stall instructions that would read or overwrite a register whose late result has not yet arrived.

---
 rtl/regfile_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter.
// The pipeline writeback path and a variable-latency late unit share one write port.
// A starvation guard forces the late request through after MAX_WAIT lost cycles.
// The winning write is registered toward the register file.
// A pending-destination scoreboard lets decode stall on RAW/WAW hazards against late results.
module regfile_wr_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pipe_valid,
    input  logic [4:0]  i_pipe_rd,
    input  logic [31:0] i_pipe_data,
    output logic        o_pipe_stall,
    input  logic        i_late_valid,
    input  logic [4:0]  i_late_rd,
    input  logic [31:0] i_late_data,
    output logic        o_late_ready,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_rd,
    input  logic        i_id_valid,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic [4:0]  i_id_rd,
    output logic        o_id_hazard,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_rd,
    output logic [31:0] o_rf_wdata
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0]  wait_cnt;
    logic [3:0]  wait_nxt;
    logic [31:0] pend;
    logic [31:0] pend_set;
    logic [31:0] pend_clr;
    logic [31:0] pend_nxt;
    logic        pipe_grant;
    logic        late_grant;

    // Arbitration: pipeline has priority until the late requester has lost MAX_WAIT times.
    always_comb begin
        pipe_grant = 1'b0;
        late_grant = 1'b0;
        if (i_late_valid && (!i_pipe_valid || (wait_cnt == WAIT_LIM))) begin
            late_grant = 1'b1;
        end else if (i_pipe_valid) begin
            pipe_grant = 1'b1;
        end else begin
            pipe_grant = 1'b0;
            late_grant = 1'b0;
        end
    end

    assign o_pipe_stall = i_pipe_valid & ~pipe_grant;
    assign o_late_ready = i_late_valid & late_grant;

    // Starvation counter: counts lost late cycles, clears on accept or when no late request.
    always_comb begin
        wait_nxt = wait_cnt;
        if (!i_late_valid || late_grant) begin
            wait_nxt = 4'd0;
        end else if (wait_cnt < WAIT_LIM) begin
            wait_nxt = wait_cnt + 4'd1;
        end else begin
            wait_nxt = wait_cnt;
        end
    end

    // Scoreboard update: clear on late accept, set on issue; set applied last so it wins.
    always_comb begin
        pend_set = 32'd0;
        pend_clr = 32'd0;
        if (i_issue_valid && (i_issue_rd != 5'd0)) begin
            pend_set[i_issue_rd] = 1'b1;
        end else begin
            pend_set = 32'd0;
        end
        if (late_grant) begin
            pend_clr[i_late_rd] = 1'b1;
        end else begin
            pend_clr = 32'd0;
        end
        pend_nxt = ((pend & ~pend_clr) | pend_set) & ~32'h0000_0001;
    end

    // Decode hazard looks only at the registered pending vector (no same-cycle bypass).
    assign o_id_hazard = i_id_valid & (pend[i_id_rs1] | pend[i_id_rs2] | pend[i_id_rd]);

    // Arbiter and scoreboard state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt <= 4'd0;
            pend     <= 32'd0;
        end else begin
            wait_cnt <= wait_nxt;
            pend     <= pend_nxt;
        end
    end

    // Registered write port; rd=0 writes complete the handshake but never assert the enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rf_we    <= 1'b0;
            o_rf_rd    <= 5'd0;
            o_rf_wdata <= 32'd0;
        end else if (late_grant) begin
            o_rf_we    <= (i_late_rd != 5'd0);
            o_rf_rd    <= i_late_rd;
            o_rf_wdata <= i_late_data;
        end else if (pipe_grant) begin
            o_rf_we    <= (i_pipe_rd != 5'd0);
            o_rf_rd    <= i_pipe_rd;
            o_rf_wdata <= i_pipe_data;
        end else begin
            o_rf_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wr_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst;
    logic        pv, lv, iv, idv;
    logic [4:0]  prd, lrd, ird, rs1, rs2, idrd;
    logic [31:0] pdata, ldata;
    logic        o_pipe_stall, o_late_ready, o_id_hazard, o_rf_we;
    logic [4:0]  o_rf_rd;
    logic [31:0] o_rf_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit        m_pend[32];
    int        m_lost;
    bit        m_we;
    bit [4:0]  m_rd;
    bit [31:0] m_wdata;
    bit        p_acc, l_acc;

    regfile_wr_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_pipe_valid(pv), .i_pipe_rd(prd), .i_pipe_data(pdata), .o_pipe_stall(o_pipe_stall),
        .i_late_valid(lv), .i_late_rd(lrd), .i_late_data(ldata), .o_late_ready(o_late_ready),
        .i_issue_valid(iv), .i_issue_rd(ird),
        .i_id_valid(idv), .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rd(idrd),
        .o_id_hazard(o_id_hazard),
        .o_rf_we(o_rf_we), .o_rf_rd(o_rf_rd), .o_rf_wdata(o_rf_wdata)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // One clock cycle: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        bit lw, pw, haz;
        #1;
        lw  = lv && (!pv || (m_lost == MAX_WAIT));
        pw  = pv && !lw;
        haz = idv && (m_pend[rs1] || m_pend[rs2] || m_pend[idrd]);
        check_eq("pipe_stall", 32'(o_pipe_stall), 32'(pv && !pw));
        check_eq("late_ready", 32'(o_late_ready), 32'(lw));
        check_eq("id_hazard",  32'(o_id_hazard),  32'(haz));
        p_acc = pw;
        l_acc = lw;
        if (rst) begin
            m_we = 1'b0; m_rd = 5'd0; m_wdata = 32'd0; m_lost = 0;
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else begin
            if (lw) begin
                m_we = (lrd != 5'd0); m_rd = lrd; m_wdata = ldata;
            end else if (pw) begin
                m_we = (prd != 5'd0); m_rd = prd; m_wdata = pdata;
            end else begin
                m_we = 1'b0;
            end
            if (!lv || lw) m_lost = 0;
            else if (m_lost < MAX_WAIT) m_lost = m_lost + 1;
            if (lw) m_pend[lrd] = 1'b0;
            if (iv && (ird != 5'd0)) m_pend[ird] = 1'b1;
            m_pend[0] = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("rf_we",    32'(o_rf_we),    32'(m_we));
        check_eq("rf_rd",    32'(o_rf_rd),    32'(m_rd));
        check_eq("rf_wdata", o_rf_wdata,      m_wdata);
    endtask

    initial begin
        rst = 1'b1; pv = 1'b0; lv = 1'b0; iv = 1'b0; idv = 1'b0;
        prd = 5'd0; lrd = 5'd0; ird = 5'd0; rs1 = 5'd0; rs2 = 5'd0; idrd = 5'd0;
        pdata = 32'd0; ldata = 32'd0;
        m_lost = 0; m_we = 1'b0; m_rd = 5'd0; m_wdata = 32'd0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        // Unchecked initial reset edge to bring the DUT out of an unknown state
        @(posedge clk); #1;

        // Reset check: pipe request not stalled, no hazard on rs1=rs2=rd=5
        pv = 1'b1; prd = 5'd5; pdata = 32'h1234_5678;
        idv = 1'b1; rs1 = 5'd5; rs2 = 5'd5; idrd = 5'd5;
        #1;
        check_eq("rst_stall",  32'(o_pipe_stall), 32'd0);
        check_eq("rst_hazard", 32'(o_id_hazard),  32'd0);
        step();
        check_eq("rst_we",    32'(o_rf_we),    32'd0);
        check_eq("rst_rd",    32'(o_rf_rd),    32'd0);
        check_eq("rst_wdata", o_rf_wdata,      32'd0);
        rst = 1'b0; pv = 1'b0; idv = 1'b0;
        step();

        // Solo pipeline write, then rd=0 write
        pv = 1'b1; prd = 5'd3; pdata = 32'hDEAD_BEEF;
        step();
        check_eq("solo_we",    32'(o_rf_we), 32'd1);
        check_eq("solo_rd",    32'(o_rf_rd), 32'd3);
        check_eq("solo_wdata", o_rf_wdata,   32'hDEAD_BEEF);
        prd = 5'd0; pdata = 32'h0BAD_0000;
        step();
        check_eq("rd0_we", 32'(o_rf_we), 32'd0);
        pv = 1'b0;
        step();

        // Contention: both valid for six cycles; late wins only on the fifth
        pv = 1'b1; lv = 1'b1; lrd = 5'd20; ldata = 32'hA5A5_0014;
        for (int c = 0; c < 6; c++) begin
            if (c != 5) begin
                prd = 5'(c + 1); pdata = 32'h0000_1000 + 32'(c);
            end
            if (c == 5) begin
                lrd = 5'd21; ldata = 32'hA5A5_0015;
            end
            #1;
            check_eq("cont_ready", 32'(o_late_ready), 32'(c == 4));
            check_eq("cont_stall", 32'(o_pipe_stall), 32'(c == 4));
            step();
        end
        // Freshly cleared counter: pipeline keeps winning the next four cycles
        for (int c = 0; c < 3; c++) begin
            prd = 5'd10; pdata = 32'h0000_2000 + 32'(c);
            #1;
            check_eq("cont_after", 32'(o_late_ready), 32'd0);
            step();
        end
        pv = 1'b0;
        step();
        lv = 1'b0;

        // Scoreboard: issue rd=7, hazard until late write to 7 is accepted
        iv = 1'b1; ird = 5'd7; idv = 1'b1; rs1 = 5'd7; rs2 = 5'd0; idrd = 5'd0;
        step();
        iv = 1'b0;
        #1;
        check_eq("sb_hazard_set", 32'(o_id_hazard), 32'd1);
        step();
        lv = 1'b1; lrd = 5'd7; ldata = 32'hCAFE_0007;
        #1;
        check_eq("sb_no_bypass", 32'(o_id_hazard), 32'd1);
        step();
        check_eq("sb_wr_we", 32'(o_rf_we), 32'd1);
        check_eq("sb_wr_rd", 32'(o_rf_rd), 32'd7);
        lv = 1'b0;
        #1;
        check_eq("sb_hazard_clr", 32'(o_id_hazard), 32'd0);
        step();

        // Simultaneous issue and late accept of rd=9: set wins
        iv = 1'b1; ird = 5'd9; rs1 = 5'd0;
        step();
        lv = 1'b1; lrd = 5'd9; ldata = 32'h0000_0009;
        step();
        iv = 1'b0; lv = 1'b0; rs2 = 5'd9;
        #1;
        check_eq("sb_set_wins", 32'(o_id_hazard), 32'd1);
        step();

        // Reset while late waits (wait count 3) and pending[12] set
        iv = 1'b1; ird = 5'd12; rs2 = 5'd0;
        step();
        iv = 1'b0;
        pv = 1'b1; prd = 5'd4; pdata = 32'h4444_4444;
        lv = 1'b1; lrd = 5'd13; ldata = 32'h1313_1313;
        for (int c = 0; c < 3; c++) step();
        rst = 1'b1;
        step();
        check_eq("mid_rst_we", 32'(o_rf_we), 32'd0);
        rst = 1'b0; pv = 1'b0; lv = 1'b0; idrd = 5'd12;
        #1;
        check_eq("mid_rst_pend", 32'(o_id_hazard), 32'd0);
        step();
        // Counter restarted at zero: late must lose four cycles again
        pv = 1'b1; lv = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq("mid_rst_wait", 32'(o_late_ready), 32'(c == 4));
            step();
        end
        pv = 1'b0; lv = 1'b0;
        step();

        // Randomized traffic; requesters hold while not accepted
        for (int n = 0; n < 600; n++) begin
            if (!(pv && !p_acc)) begin
                pv = ($urandom_range(0, 9) < 6);
                prd = 5'($urandom_range(0, 15));
                pdata = $urandom;
            end
            if (!(lv && !l_acc)) begin
                lv = ($urandom_range(0, 9) < 4);
                lrd = 5'($urandom_range(0, 15));
                ldata = $urandom;
            end
            iv   = ($urandom_range(0, 9) < 3);
            ird  = 5'($urandom_range(0, 15));
            idv  = ($urandom_range(0, 9) < 7);
            rs1  = 5'($urandom_range(0, 15));
            rs2  = 5'($urandom_range(0, 15));
            idrd = 5'($urandom_range(0, 15));
            rst  = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
